// File: rtl/comp_ll_arb.sv
// rtl/comp_ll_arb.sv - frame arbiter sharing one comp engine local-link pair between two DMA channels
module comp_ll_arb #(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_AW    = 2
) (
    input  logic              CPMDMALLCLK,
    input  logic              DMALLRSTENGINEACK,
    input  logic [31:0]       S0_TXD,
    input  logic [3:0]        S0_TXREM,
    input  logic              S0_TXSOFN,
    input  logic              S0_TXEOFN,
    input  logic              S0_TXSOPN,
    input  logic              S0_TXEOPN,
    input  logic              S0_TXSRCRDYN,
    output logic              S0_TXDSTRDYN,
    input  logic [31:0]       S1_TXD,
    input  logic [3:0]        S1_TXREM,
    input  logic              S1_TXSOFN,
    input  logic              S1_TXEOFN,
    input  logic              S1_TXSOPN,
    input  logic              S1_TXEOPN,
    input  logic              S1_TXSRCRDYN,
    output logic              S1_TXDSTRDYN,
    output logic [31:0]       E_TXD,
    output logic [3:0]        E_TXREM,
    output logic              E_TXSOFN,
    output logic              E_TXEOFN,
    output logic              E_TXSOPN,
    output logic              E_TXEOPN,
    output logic              E_TXSRCRDYN,
    input  logic              E_TXDSTRDYN,
    input  logic [31:0]       E_RXD,
    input  logic [3:0]        E_RXREM,
    input  logic              E_RXSOFN,
    input  logic              E_RXEOFN,
    input  logic              E_RXSOPN,
    input  logic              E_RXEOPN,
    input  logic              E_RXSRCRDYN,
    output logic              E_RXDSTRDYN,
    output logic [31:0]       S0_RXD,
    output logic [3:0]        S0_RXREM,
    output logic              S0_RXSOFN,
    output logic              S0_RXEOFN,
    output logic              S0_RXSOPN,
    output logic              S0_RXEOPN,
    output logic              S0_RXSRCRDYN,
    input  logic              S0_RXDSTRDYN,
    output logic [31:0]       S1_RXD,
    output logic [3:0]        S1_RXREM,
    output logic              S1_RXSOFN,
    output logic              S1_RXEOFN,
    output logic              S1_RXSOPN,
    output logic              S1_RXEOPN,
    output logic              S1_RXSRCRDYN,
    input  logic              S1_RXDSTRDYN,
    output logic [TAG_AW:0]   TAG_CNT,
    output logic              GNT_ID
);

    typedef enum logic {TX_IDLE, TX_XFER} tx_state_t;
    typedef enum logic {RX_IDLE, RX_ROUTE} rx_state_t;

    localparam logic [TAG_AW:0] CNT_FULL = (TAG_AW+1)'(TAG_DEPTH);
    localparam logic [TAG_AW:0] CNT_ONE  = (TAG_AW+1)'(1);

    tx_state_t          tx_state, tx_state_nxt;
    rx_state_t          rx_state, rx_state_nxt;
    logic               gnt_id;
    logic               tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0]  wr_ptr, rd_ptr;
    logic [TAG_AW:0]    tag_cnt;

    logic req0, req1, fifo_full, grant, win;
    logic sel_srcrdyn, sel_eofn, tx_beat, tx_done;
    logic head, rx_beat, rx_done, sel_rxdstrdyn;

    assign req0      = !S0_TXSRCRDYN && !S0_TXSOFN;
    assign req1      = !S1_TXSRCRDYN && !S1_TXSOFN;
    assign fifo_full = (tag_cnt == CNT_FULL);
    assign grant     = (tx_state == TX_IDLE) && (req0 || req1) && !fifo_full;
    // On a tie the channel that did not hold the last grant wins.
    assign win       = (req0 && req1) ? ~gnt_id : req1;

    assign sel_srcrdyn = gnt_id ? S1_TXSRCRDYN : S0_TXSRCRDYN;
    assign sel_eofn    = gnt_id ? S1_TXEOFN    : S0_TXEOFN;
    assign tx_beat     = (tx_state == TX_XFER) && !sel_srcrdyn && !E_TXDSTRDYN;
    assign tx_done     = tx_beat && !sel_eofn;

    // Head tag is stable through ROUTE because it is only popped on the EOF beat.
    assign head          = tag_mem[rd_ptr];
    assign sel_rxdstrdyn = head ? S1_RXDSTRDYN : S0_RXDSTRDYN;
    assign rx_beat       = (rx_state == RX_ROUTE) && !E_RXSRCRDYN && !sel_rxdstrdyn;
    assign rx_done       = rx_beat && !E_RXEOFN;

    always_ff @(posedge CPMDMALLCLK or posedge DMALLRSTENGINEACK) begin
        if (DMALLRSTENGINEACK) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
            gnt_id   <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag_cnt  <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
            if (grant) begin
                gnt_id          <= win;
                tag_mem[wr_ptr] <= win;
                wr_ptr          <= wr_ptr + TAG_AW'(1);
            end
            if (rx_done) rd_ptr <= rd_ptr + TAG_AW'(1);
            if (grant && !rx_done)      tag_cnt <= tag_cnt + CNT_ONE;
            else if (!grant && rx_done) tag_cnt <= tag_cnt - CNT_ONE;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        rx_state_nxt = rx_state;
        case (tx_state)
            TX_IDLE: if (grant)   tx_state_nxt = TX_XFER;
            TX_XFER: if (tx_done) tx_state_nxt = TX_IDLE;
            default:              tx_state_nxt = TX_IDLE;
        endcase
        case (rx_state)
            RX_IDLE:  if (tag_cnt != '0) rx_state_nxt = RX_ROUTE;
            RX_ROUTE: if (rx_done)       rx_state_nxt = RX_IDLE;
            default:                     rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        S0_TXDSTRDYN = 1'b1;
        S1_TXDSTRDYN = 1'b1;
        E_TXD        = '0;
        E_TXREM      = '0;
        E_TXSOFN     = 1'b1;
        E_TXEOFN     = 1'b1;
        E_TXSOPN     = 1'b1;
        E_TXEOPN     = 1'b1;
        E_TXSRCRDYN  = 1'b1;
        if (tx_state == TX_XFER) begin
            if (gnt_id) begin
                E_TXD        = S1_TXD;
                E_TXREM      = S1_TXREM;
                E_TXSOFN     = S1_TXSOFN;
                E_TXEOFN     = S1_TXEOFN;
                E_TXSOPN     = S1_TXSOPN;
                E_TXEOPN     = S1_TXEOPN;
                E_TXSRCRDYN  = S1_TXSRCRDYN;
                S1_TXDSTRDYN = E_TXDSTRDYN;
            end else begin
                E_TXD        = S0_TXD;
                E_TXREM      = S0_TXREM;
                E_TXSOFN     = S0_TXSOFN;
                E_TXEOFN     = S0_TXEOFN;
                E_TXSOPN     = S0_TXSOPN;
                E_TXEOPN     = S0_TXEOPN;
                E_TXSRCRDYN  = S0_TXSRCRDYN;
                S0_TXDSTRDYN = E_TXDSTRDYN;
            end
        end
    end

    always_comb begin
        E_RXDSTRDYN  = 1'b1;
        S0_RXD       = '0;
        S0_RXREM     = '0;
        S0_RXSOFN    = 1'b1;
        S0_RXEOFN    = 1'b1;
        S0_RXSOPN    = 1'b1;
        S0_RXEOPN    = 1'b1;
        S0_RXSRCRDYN = 1'b1;
        S1_RXD       = '0;
        S1_RXREM     = '0;
        S1_RXSOFN    = 1'b1;
        S1_RXEOFN    = 1'b1;
        S1_RXSOPN    = 1'b1;
        S1_RXEOPN    = 1'b1;
        S1_RXSRCRDYN = 1'b1;
        if (rx_state == RX_ROUTE) begin
            E_RXDSTRDYN = sel_rxdstrdyn;
            if (head) begin
                S1_RXD       = E_RXD;
                S1_RXREM     = E_RXREM;
                S1_RXSOFN    = E_RXSOFN;
                S1_RXEOFN    = E_RXEOFN;
                S1_RXSOPN    = E_RXSOPN;
                S1_RXEOPN    = E_RXEOPN;
                S1_RXSRCRDYN = E_RXSRCRDYN;
            end else begin
                S0_RXD       = E_RXD;
                S0_RXREM     = E_RXREM;
                S0_RXSOFN    = E_RXSOFN;
                S0_RXEOFN    = E_RXEOFN;
                S0_RXSOPN    = E_RXSOPN;
                S0_RXEOPN    = E_RXEOPN;
                S0_RXSRCRDYN = E_RXSRCRDYN;
            end
        end
    end

    assign TAG_CNT = tag_cnt;
    assign GNT_ID  = gnt_id;

endmodule

// File: tb/tb_comp_ll_arb.sv
// tb/tb_comp_ll_arb.sv - self-checking bench for comp_ll_arb
module tb_comp_ll_arb;

    localparam logic [40:0] IDLE_B = {36'd0, 5'h1F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] s_txd [2];
    logic [3:0]  s_txrem [2];
    logic        s_txsofn [2], s_txeofn [2], s_txsopn [2], s_txeopn [2], s_txsrcrdyn [2];
    logic        s_rxdstrdyn [2];
    logic        e_txdstrdyn;
    logic [31:0] e_rxd;
    logic [3:0]  e_rxrem;
    logic        e_rxsofn, e_rxeofn, e_rxsopn, e_rxeopn, e_rxsrcrdyn;

    logic        s0_txdstrdyn, s1_txdstrdyn, e_rxdstrdyn, gnt_id;
    logic [31:0] e_txd, s0_rxd, s1_rxd;
    logic [3:0]  e_txrem, s0_rxrem, s1_rxrem;
    logic        e_txsofn, e_txeofn, e_txsopn, e_txeopn, e_txsrcrdyn;
    logic        s0_rxsofn, s0_rxeofn, s0_rxsopn, s0_rxeopn, s0_rxsrcrdyn;
    logic        s1_rxsofn, s1_rxeofn, s1_rxsopn, s1_rxeopn, s1_rxsrcrdyn;
    logic [2:0]  tag_cnt;

    comp_ll_arb #(.TAG_DEPTH(4), .TAG_AW(2)) dut (
        .CPMDMALLCLK(clk), .DMALLRSTENGINEACK(rst),
        .S0_TXD(s_txd[0]), .S0_TXREM(s_txrem[0]), .S0_TXSOFN(s_txsofn[0]), .S0_TXEOFN(s_txeofn[0]),
        .S0_TXSOPN(s_txsopn[0]), .S0_TXEOPN(s_txeopn[0]), .S0_TXSRCRDYN(s_txsrcrdyn[0]), .S0_TXDSTRDYN(s0_txdstrdyn),
        .S1_TXD(s_txd[1]), .S1_TXREM(s_txrem[1]), .S1_TXSOFN(s_txsofn[1]), .S1_TXEOFN(s_txeofn[1]),
        .S1_TXSOPN(s_txsopn[1]), .S1_TXEOPN(s_txeopn[1]), .S1_TXSRCRDYN(s_txsrcrdyn[1]), .S1_TXDSTRDYN(s1_txdstrdyn),
        .E_TXD(e_txd), .E_TXREM(e_txrem), .E_TXSOFN(e_txsofn), .E_TXEOFN(e_txeofn),
        .E_TXSOPN(e_txsopn), .E_TXEOPN(e_txeopn), .E_TXSRCRDYN(e_txsrcrdyn), .E_TXDSTRDYN(e_txdstrdyn),
        .E_RXD(e_rxd), .E_RXREM(e_rxrem), .E_RXSOFN(e_rxsofn), .E_RXEOFN(e_rxeofn),
        .E_RXSOPN(e_rxsopn), .E_RXEOPN(e_rxeopn), .E_RXSRCRDYN(e_rxsrcrdyn), .E_RXDSTRDYN(e_rxdstrdyn),
        .S0_RXD(s0_rxd), .S0_RXREM(s0_rxrem), .S0_RXSOFN(s0_rxsofn), .S0_RXEOFN(s0_rxeofn),
        .S0_RXSOPN(s0_rxsopn), .S0_RXEOPN(s0_rxeopn), .S0_RXSRCRDYN(s0_rxsrcrdyn), .S0_RXDSTRDYN(s_rxdstrdyn[0]),
        .S1_RXD(s1_rxd), .S1_RXREM(s1_rxrem), .S1_RXSOFN(s1_rxsofn), .S1_RXEOFN(s1_rxeofn),
        .S1_RXSOPN(s1_rxsopn), .S1_RXEOPN(s1_rxeopn), .S1_RXSRCRDYN(s1_rxsrcrdyn), .S1_RXDSTRDYN(s_rxdstrdyn[1]),
        .TAG_CNT(tag_cnt), .GNT_ID(gnt_id)
    );

    logic [40:0] etx_got, rx0_got, rx1_got;
    assign etx_got = {e_txd, e_txrem, e_txsofn, e_txeofn, e_txsopn, e_txeopn, e_txsrcrdyn};
    assign rx0_got = {s0_rxd, s0_rxrem, s0_rxsofn, s0_rxeofn, s0_rxsopn, s0_rxeopn, s0_rxsrcrdyn};
    assign rx1_got = {s1_rxd, s1_rxrem, s1_rxsofn, s1_rxeofn, s1_rxsopn, s1_rxeopn, s1_rxsrcrdyn};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Beat = {sof, eof, data}; stimulus sources
    logic [33:0] q0[$], q1[$], erx_q[$];
    logic acc0, acc1, acc_erx;

    // Behavioural model: who owns each side, plus the ordered list of outstanding tags
    int tx_own = -1, rx_own = -1, last_gnt = 1;
    int tagq[$];
    logic [31:0] etx_log[$];
    int gnt_log[$];
    int rx_n [2] = '{0, 0};

    always @(negedge clk) begin
        logic [40:0] exp_etx, exp_rx0, exp_rx1, erx_b;
        logic exp_d0, exp_d1, exp_erxd, txb, rxb, r0, r1, pop;
        int sz, w;
        if (rst) begin
            tx_own = -1; rx_own = -1; last_gnt = 1;
            tagq.delete();
            acc0 = 0; acc1 = 0; acc_erx = 0;
            chk("rst_etx", etx_got, IDLE_B);
            chk("rst_rx0", rx0_got, IDLE_B);
            chk("rst_rx1", rx1_got, IDLE_B);
            chk("rst_dst", {s0_txdstrdyn, s1_txdstrdyn, e_rxdstrdyn}, 3'b111);
            chk("rst_cnt", tag_cnt, 0);
            chk("rst_gnt", gnt_id, 1);
        end else begin
            exp_etx = IDLE_B; exp_d0 = 1; exp_d1 = 1;
            if (tx_own >= 0) begin
                exp_etx = {s_txd[tx_own], s_txrem[tx_own], s_txsofn[tx_own], s_txeofn[tx_own],
                           s_txsopn[tx_own], s_txeopn[tx_own], s_txsrcrdyn[tx_own]};
                if (tx_own == 0) exp_d0 = e_txdstrdyn; else exp_d1 = e_txdstrdyn;
            end
            erx_b = {e_rxd, e_rxrem, e_rxsofn, e_rxeofn, e_rxsopn, e_rxeopn, e_rxsrcrdyn};
            exp_rx0 = (rx_own == 0) ? erx_b : IDLE_B;
            exp_rx1 = (rx_own == 1) ? erx_b : IDLE_B;
            exp_erxd = (rx_own >= 0) ? s_rxdstrdyn[rx_own] : 1'b1;
            chk("etx", etx_got, exp_etx);
            chk("s0_txdst", s0_txdstrdyn, exp_d0);
            chk("s1_txdst", s1_txdstrdyn, exp_d1);
            chk("rx0", rx0_got, exp_rx0);
            chk("rx1", rx1_got, exp_rx1);
            chk("erx_dst", e_rxdstrdyn, exp_erxd);
            chk("tag_cnt", tag_cnt, tagq.size());
            chk("gnt_id", gnt_id, last_gnt);

            txb = (tx_own >= 0) && !s_txsrcrdyn[tx_own] && !e_txdstrdyn;
            rxb = (rx_own >= 0) && !e_rxsrcrdyn && !s_rxdstrdyn[rx_own];
            acc0 = txb && tx_own == 0;
            acc1 = txb && tx_own == 1;
            acc_erx = rxb;
            if (!e_txsrcrdyn && !e_txdstrdyn) begin
                etx_log.push_back(e_txd);
                if (!e_txsofn) gnt_log.push_back(int'(gnt_id));
            end
            if (!s0_rxsrcrdyn && !s_rxdstrdyn[0]) rx_n[0]++;
            if (!s1_rxsrcrdyn && !s_rxdstrdyn[1]) rx_n[1]++;

            sz = tagq.size();
            pop = rxb && !e_rxeofn;
            if (rx_own >= 0 && pop) rx_own = -1;
            else if (rx_own < 0 && sz > 0) rx_own = tagq[0];
            if (tx_own >= 0) begin
                if (txb && !s_txeofn[tx_own]) tx_own = -1;
            end else begin
                r0 = !s_txsrcrdyn[0] && !s_txsofn[0];
                r1 = !s_txsrcrdyn[1] && !s_txsofn[1];
                if ((r0 || r1) && sz < 4) begin
                    w = (r0 && r1) ? 1 - last_gnt : (r1 ? 1 : 0);
                    tx_own = w; last_gnt = w;
                    tagq.push_back(w);
                end
            end
            if (pop) void'(tagq.pop_front());
        end
    end

    task automatic drive();
        logic [33:0] b;
        for (int c = 0; c < 2; c++) begin
            if ((c == 0 && q0.size() > 0) || (c == 1 && q1.size() > 0)) begin
                b = (c == 0) ? q0[0] : q1[0];
                s_txsrcrdyn[c] = 0; s_txsofn[c] = !b[33]; s_txeofn[c] = !b[32];
                s_txd[c] = b[31:0]; s_txrem[c] = b[3:0]; s_txsopn[c] = b[4]; s_txeopn[c] = b[5];
            end else begin
                s_txsrcrdyn[c] = 1; s_txsofn[c] = 1; s_txeofn[c] = 1;
                s_txd[c] = 0; s_txrem[c] = 0; s_txsopn[c] = 1; s_txeopn[c] = 1;
            end
        end
        if (erx_q.size() > 0) begin
            b = erx_q[0];
            e_rxsrcrdyn = 0; e_rxsofn = !b[33]; e_rxeofn = !b[32];
            e_rxd = b[31:0]; e_rxrem = b[7:4]; e_rxsopn = b[6]; e_rxeopn = b[7];
        end else begin
            e_rxsrcrdyn = 1; e_rxsofn = 1; e_rxeofn = 1;
            e_rxd = 0; e_rxrem = 0; e_rxsopn = 1; e_rxeopn = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0 && q0.size() > 0) void'(q0.pop_front());
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        if (acc_erx && erx_q.size() > 0) void'(erx_q.pop_front());
        drive();
    endtask

    task automatic add_frame(input int ch, input int n, input logic [31:0] base);
        logic [33:0] b;
        for (int i = 0; i < n; i++) begin
            b = {i == 0, i == n - 1, base + 32'(i)};
            if (ch == 0) q0.push_back(b);
            else if (ch == 1) q1.push_back(b);
            else erx_q.push_back(b);
        end
    endtask

    task automatic wait_tx(input string name);
        for (int k = 0; k < 300 && (q0.size() > 0 || q1.size() > 0); k++) step();
        chk(name, q0.size() + q1.size(), 0);
    endtask

    task automatic wait_rx(input string name, input bit stall1);
        for (int k = 0; k < 300 && erx_q.size() > 0; k++) begin
            if (stall1) s_rxdstrdyn[1] = (k % 3 != 0);
            step();
        end
        s_rxdstrdyn[1] = 0;
        chk(name, erx_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        q0.delete(); q1.delete(); erx_q.delete();
        drive();
        step(); step();
        rst = 0;
        step();
    endtask

    int base, r0b, r1b;

    initial begin
        e_txdstrdyn = 0;
        s_rxdstrdyn[0] = 0;
        s_rxdstrdyn[1] = 0;
        drive();
        do_reset();
        chk("init_cnt", tag_cnt, 0);
        chk("init_gnt", gnt_id, 1);
        chk("init_etx_src", e_txsrcrdyn, 1);
        chk("init_erx_dst", e_rxdstrdyn, 1);

        // Single S0 frame of 10 beats, then its 3-beat result
        base = etx_log.size();
        add_frame(0, 10, 32'h100);
        drive();
        wait_tx("t1_drain");
        chk("t1_beats", etx_log.size() - base, 10);
        for (int i = 0; i < 10; i++)
            if (base + i < etx_log.size()) chk("t1_data", etx_log[base + i], 32'h100 + 32'(i));
        chk("t1_cnt", tag_cnt, 1);
        r0b = rx_n[0]; r1b = rx_n[1];
        add_frame(2, 3, 32'hA00);
        drive();
        wait_rx("t1_rx_drain", 0);
        step();
        chk("t1_cnt_after", tag_cnt, 0);
        chk("t1_rx0_beats", rx_n[0] - r0b, 3);
        chk("t1_rx1_beats", rx_n[1] - r1b, 0);

        // Simultaneous requests from reset alternate starting with S0
        do_reset();
        base = gnt_log.size();
        add_frame(0, 2, 32'h200); add_frame(1, 2, 32'h300);
        add_frame(0, 2, 32'h210); add_frame(1, 2, 32'h310);
        drive();
        wait_tx("t2_drain");
        chk("t2_grants", gnt_log.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < gnt_log.size()) chk("t2_gnt_seq", gnt_log[base + i], i % 2);
        chk("t2_cnt", tag_cnt, 4);
        r0b = rx_n[0]; r1b = rx_n[1];
        for (int i = 0; i < 4; i++) add_frame(2, 2, 32'hB00 + 32'(16 * i));
        drive();
        wait_rx("t2_rx_drain", 1);
        step();
        chk("t2_rx0_beats", rx_n[0] - r0b, 4);
        chk("t2_rx1_beats", rx_n[1] - r1b, 4);
        chk("t2_cnt_after", tag_cnt, 0);

        // Push and pop on the same edge at TAG_CNT=2
        do_reset();
        add_frame(0, 1, 32'h400); add_frame(0, 1, 32'h401);
        drive();
        wait_tx("t4_fill");
        chk("t4_cnt2", tag_cnt, 2);
        add_frame(0, 1, 32'h402); add_frame(2, 1, 32'hC00);
        drive();
        step();
        chk("t4_cnt_same", tag_cnt, 2);
        add_frame(2, 1, 32'hC01); add_frame(2, 1, 32'hC02);
        drive();
        wait_rx("t4_rx_drain", 0);
        step();
        chk("t4_cnt_after", tag_cnt, 0);

        // Tag FIFO full holds the fifth S1 request until one result frame retires
        do_reset();
        for (int i = 0; i < 5; i++) add_frame(1, 2, 32'h500 + 32'(16 * i));
        drive();
        for (int k = 0; k < 100 && q1.size() > 2; k++) step();
        for (int k = 0; k < 4; k++) step();
        chk("t3_full_cnt", tag_cnt, 4);
        chk("t3_held", q1.size(), 2);
        chk("t3_held_dst", s1_txdstrdyn, 1);
        chk("t3_held_src", e_txsrcrdyn, 1);
        add_frame(2, 1, 32'hD00);
        drive();
        wait_rx("t3_rx_one", 0);
        chk("t3_cnt3", tag_cnt, 3);
        step();
        chk("t3_cnt4", tag_cnt, 4);
        chk("t3_gnt5", e_txsrcrdyn, 0);
        for (int i = 0; i < 4; i++) add_frame(2, 2, 32'hD10 + 32'(16 * i));
        add_frame(1, 3, 32'h600);
        drive();
        wait_rx("t3_rx_drain", 0);
        wait_tx("t3_tx_drain");
        add_frame(2, 1, 32'hD80);
        drive();
        wait_rx("t3_rx_last", 0);
        step();
        chk("t3_cnt_end", tag_cnt, 0);

        // Reset mid-XFER and mid-ROUTE, then S0 wins the first tie again
        do_reset();
        add_frame(0, 20, 32'h700);
        add_frame(2, 20, 32'hE00);
        drive();
        for (int k = 0; k < 6; k++) step();
        chk("t5_in_xfer", e_txsrcrdyn, 0);
        chk("t5_in_route", s0_rxsrcrdyn, 0);
        #2;
        rst = 1;
        q0.delete(); q1.delete(); erx_q.delete();
        drive();
        #1;
        chk("t5_async_txdst", {s0_txdstrdyn, s1_txdstrdyn}, 2'b11);
        chk("t5_async_src", {e_txsrcrdyn, s0_rxsrcrdyn, s1_rxsrcrdyn}, 3'b111);
        chk("t5_async_erxdst", e_rxdstrdyn, 1);
        chk("t5_async_cnt", tag_cnt, 0);
        step(); step();
        rst = 0;
        base = gnt_log.size();
        add_frame(0, 2, 32'h800); add_frame(1, 2, 32'h900);
        drive();
        wait_tx("t5_drain");
        chk("t5_grants", gnt_log.size() - base, 2);
        if (gnt_log.size() > base) chk("t5_first_gnt", gnt_log[base], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
